// File: rtl/bch_pkg.sv
// Shared definitions for the double-error-correcting BCH decoder:
// default field/code sizes, FSM state encoding and GF(2^m) helpers.
package bch_pkg;

  localparam int unsigned M_DEF = 6;
  localparam int unsigned K_DEF = 32;
  localparam logic [6:0]  PRIM_POLY_DEF = 7'b1000011;

  // Widest field and codeword the helper functions are written for.
  localparam int unsigned GF_MW = 8;
  localparam int unsigned CW_MW = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYN,
    ST_KEY,
    ST_CHIEN,
    ST_DONE
  } bch_state_e;

  // Multiply an element of GF(2^m) by alpha. The shifted-out x^m term is
  // cancelled by the x^m bit of the primitive polynomial.
  function automatic logic [GF_MW-1:0] gf_mul_alpha(
    input logic [GF_MW-1:0] a,
    input int unsigned      m,
    input logic [GF_MW:0]   poly
  );
    logic [GF_MW:0] t;
    t = {a, 1'b0};
    if (t[m]) t = t ^ poly;
    return t[GF_MW-1:0];
  endfunction

  // alpha^e in GF(2^m); intended for elaboration-time constants.
  function automatic logic [GF_MW-1:0] gf_alpha_pow(
    input int unsigned    e,
    input int unsigned    m,
    input logic [GF_MW:0] poly
  );
    logic [GF_MW-1:0] r;
    int unsigned      er;
    r  = GF_MW'(1);
    er = e % ((32'd1 << m) - 32'd1);
    for (int unsigned k = 0; k < er; k++) r = gf_mul_alpha(r, m, poly);
    return r;
  endfunction

  // r(alpha^p) for an n-bit received word; bit i is the x^i coefficient.
  // The running power depends only on constants, so this reduces to an
  // XOR network per syndrome bit.
  function automatic logic [GF_MW-1:0] gf_syndrome(
    input logic [CW_MW-1:0] cw,
    input int unsigned      n,
    input int unsigned      p,
    input int unsigned      m,
    input logic [GF_MW:0]   poly
  );
    logic [GF_MW-1:0] acc;
    logic [GF_MW-1:0] pw;
    acc = '0;
    pw  = GF_MW'(1);
    for (int unsigned i = 0; i < n; i++) begin
      if (cw[i]) acc = acc ^ pw;
      for (int unsigned j = 0; j < p; j++) pw = gf_mul_alpha(pw, m, poly);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^M) multiplier, shift-and-add reduced by PRIM_POLY.
module gf_mul
  import bch_pkg::*;
#(
  parameter int unsigned M         = M_DEF,
  parameter logic [M:0]  PRIM_POLY = PRIM_POLY_DEF
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] acc;
  logic [M-1:0] sh;

  // Accumulate a*alpha^i for every set bit i of b.
  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM_POLY[M-1:0] : '0);
    end
    p = acc;
  end

endmodule

// File: rtl/bch_dec_seq.sv
// Sequential double-error-correcting BCH decoder: syndromes, inversion-free
// error locator, then an N-cycle Chien search over every bit position.
module bch_dec_seq
  import bch_pkg::*;
#(
  parameter int unsigned M         = M_DEF,
  parameter int unsigned K         = K_DEF,
  parameter logic [M:0]  PRIM_POLY = PRIM_POLY_DEF,
  localparam int unsigned N        = K + 2*M
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_cw,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K-1:0]   out_data,
  output logic [2*M-1:0] out_syn,
  output logic           out_err,
  output logic           out_sgl,
  output logic           out_dbl,
  output logic           out_unc
);

  localparam int unsigned    IW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned    Q        = (32'd1 << M) - 32'd1;
  localparam logic [GF_MW:0] POLY_EXT = (GF_MW+1)'(PRIM_POLY);
  localparam logic [M-1:0]   AINV1    = M'(gf_alpha_pow(Q - 1, M, POLY_EXT));
  localparam logic [M-1:0]   AINV2    = M'(gf_alpha_pow(Q - 2, M, POLY_EXT));

  bch_state_e     state_q, state_d;
  logic [N-1:0]   cw_q, cw_d;
  logic [M-1:0]   s1_q, s1_d, s3_q, s3_d;
  logic [M-1:0]   l0_q, l0_d, l1_q, l1_d, l2_q, l2_d;
  logic           key_ph_q, key_ph_d;
  logic [M-1:0]   t1_q, t1_d, t2_q, t2_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [K-1:0]   out_data_q, out_data_d;
  logic [2*M-1:0] out_syn_q, out_syn_d;
  logic           out_err_q, out_err_d;
  logic           out_sgl_q, out_sgl_d;
  logic           out_dbl_q, out_dbl_d;
  logic           out_unc_q, out_unc_d;

  logic [M-1:0]   s1_c, s3_c, s1_sq, s1_cu, t1_nx, t2_nx;
  logic           root_hit;
  logic [1:0]     roots_want;

  gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_sq (.a(s1_q),  .b(s1_q),  .p(s1_sq));
  gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_cu (.a(s1_sq), .b(s1_q),  .p(s1_cu));
  gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_t1 (.a(t1_q),  .b(AINV1), .p(t1_nx));
  gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_t2 (.a(t2_q),  .b(AINV2), .p(t2_nx));

  // Syndrome evaluation of the captured word and Chien root detection.
  always_comb begin
    s1_c       = M'(gf_syndrome(CW_MW'(cw_q), N, 1, M, POLY_EXT));
    s3_c       = M'(gf_syndrome(CW_MW'(cw_q), N, 3, M, POLY_EXT));
    root_hit   = ((l0_q ^ t1_q ^ t2_q) == '0);
    roots_want = (l2_q == '0) ? 2'd1 : 2'd2;
  end

  // Next-state and registered-output logic for the decode sequence.
  // KEY takes two cycles: the first registers the locator, the second
  // chooses between the skip paths and the Chien search.
  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    s1_d        = s1_q;
    s3_d        = s3_q;
    l0_d        = l0_q;
    l1_d        = l1_q;
    l2_d        = l2_q;
    key_ph_d    = key_ph_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_syn_d   = out_syn_q;
    out_err_d   = out_err_q;
    out_sgl_d   = out_sgl_q;
    out_dbl_d   = out_dbl_q;
    out_unc_d   = out_unc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cw_d       = in_cw;
          in_ready_d = 1'b0;
          state_d    = ST_SYN;
        end
      end

      ST_SYN: begin
        s1_d     = s1_c;
        s3_d     = s3_c;
        key_ph_d = 1'b0;
        state_d  = ST_KEY;
      end

      ST_KEY: begin
        if (!key_ph_q) begin
          l0_d     = s1_q;
          l1_d     = s1_sq;
          l2_d     = s1_cu ^ s3_q;
          key_ph_d = 1'b1;
        end else if (s1_q == '0) begin
          out_valid_d = 1'b1;
          out_data_d  = cw_q[N-1:2*M];
          out_syn_d   = {s3_q, s1_q};
          out_err_d   = (s3_q != '0);
          out_unc_d   = (s3_q != '0);
          out_sgl_d   = 1'b0;
          out_dbl_d   = 1'b0;
          state_d     = ST_DONE;
        end else begin
          t1_d    = l1_q;
          t2_d    = l2_q;
          idx_d   = '0;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = ST_CHIEN;
        end
      end

      ST_CHIEN: begin
        t1_d  = t1_nx;
        t2_d  = t2_nx;
        idx_d = idx_q + IW'(1);
        if (root_hit) begin
          mask_d[idx_q] = 1'b1;
          cnt_d         = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
        end
        // The last position's hit is folded in from mask_d/cnt_d so the
        // verdict lands on the same edge that enters DONE.
        if (idx_q == IW'(N - 1)) begin
          out_valid_d = 1'b1;
          out_syn_d   = {s3_q, s1_q};
          out_err_d   = 1'b1;
          if (cnt_d == roots_want) begin
            out_data_d = cw_q[N-1:2*M] ^ mask_d[N-1:2*M];
            out_sgl_d  = (roots_want == 2'd1);
            out_dbl_d  = (roots_want == 2'd2);
            out_unc_d  = 1'b0;
          end else begin
            out_data_d = cw_q[N-1:2*M];
            out_sgl_d  = 1'b0;
            out_dbl_d  = 1'b0;
            out_unc_d  = 1'b1;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cw_q        <= '0;
      s1_q        <= '0;
      s3_q        <= '0;
      l0_q        <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      key_ph_q    <= 1'b0;
      t1_q        <= '0;
      t2_q        <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_syn_q   <= '0;
      out_err_q   <= 1'b0;
      out_sgl_q   <= 1'b0;
      out_dbl_q   <= 1'b0;
      out_unc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      s1_q        <= s1_d;
      s3_q        <= s3_d;
      l0_q        <= l0_d;
      l1_q        <= l1_d;
      l2_q        <= l2_d;
      key_ph_q    <= key_ph_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_syn_q   <= out_syn_d;
      out_err_q   <= out_err_d;
      out_sgl_q   <= out_sgl_d;
      out_dbl_q   <= out_dbl_d;
      out_unc_q   <= out_unc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_syn   = out_syn_q;
  assign out_err   = out_err_q;
  assign out_sgl   = out_sgl_q;
  assign out_dbl   = out_dbl_q;
  assign out_unc   = out_unc_q;

endmodule

// File: doc/bch_dec_seq.md
BCH_DEC_SEQ -- requirements
Module: bch_dec_seq

Interface
REQ-001 SHALL have parameter M, default 6, Galois-field degree GF(2^M).
REQ-002 SHALL have parameter K, default 32, data bits per codeword.
REQ-003 SHALL have parameter PRIM_POLY, default 7'b1000011, primitive polynomial of GF(2^M).
REQ-004 SHALL derive N = K+2*M (default 44); N <= 2^M-1 is a legal-configuration requirement.
REQ-005 Ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  codeword present
  in_ready  out  1  block can accept
  in_cw  in  N  received codeword; bit i = coefficient of x^i; data in [N-1:2M], parity in [2M-1:0]
  out_valid  out  1  result present
  out_ready  in  1  consumer accepts
  out_data  out  K  corrected data
  out_syn  out  2M  {S3,S1}
  out_err  out  1  syndrome nonzero
  out_sgl  out  1  one error corrected
  out_dbl  out  1  two errors corrected
  out_unc  out  1  uncorrectable; data passed uncorrected
REQ-006 SHALL have one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-007 SHALL implement FSM IDLE -> SYN -> KEY -> {CHIEN | DONE}, CHIEN -> DONE, DONE -> IDLE.
REQ-008 in_ready SHALL equal (state==IDLE); transfer occurs on the edge where in_valid && in_ready, capturing in_cw (edge C).
REQ-009 SYN: S1 = r(alpha), S3 = r(alpha^3) over GF(2^M), registered at C+1.
REQ-010 KEY: Lambda0=S1, Lambda1=S1^2, Lambda2=S3+S1^3 (inversion-free locator), registered at C+2.
REQ-011 S1==0 && S3==0: out_err=0, go to DONE, no correction.
REQ-012 S1==0 && S3!=0: out_unc=1, go to DONE, no Chien search.
REQ-013 Otherwise CHIEN for exactly N cycles, position i=0..N-1; t1 starts at Lambda1 and is multiplied by alpha^-1 each cycle; t2 starts at Lambda2 and is multiplied by alpha^-2 each cycle; position i is an error when Lambda0+t1+t2==0; set mask bit i and increment root count.
REQ-014 Expected roots: 1 if Lambda2==0, else 2. Count equal -> out_sgl or out_dbl=1 and out_data = (cw ^ mask)[N-1:2M]. Count unequal -> out_unc=1 and out_data = cw[N-1:2M].
REQ-015 out_valid SHALL rise at edge C+3 on the skip paths and at C+3+N on the Chien path; it is asserted only in DONE.
REQ-016 In DONE, all out_* SHALL hold stable until out_valid && out_ready; the FSM then returns to IDLE, and in_ready=1 on the next cycle (no back-to-back overlap).
REQ-017 At most one of out_sgl/out_dbl/out_unc SHALL be 1; out_err=1 whenever any of them is 1.
REQ-018 All GF arithmetic SHALL be M-bit, reduced modulo PRIM_POLY; the root counter SHALL be 2 bits, saturating at 3.

Reset
REQ-019 rst_n low SHALL immediately force state=IDLE, in_ready=1 after release, out_valid=0, and all out_* flags, out_data and out_syn to 0, regardless of state.
REQ-020 Reset asserted mid-CHIEN or mid-DONE SHALL discard the codeword; no out_valid pulse follows release.

Structure
REQ-021 Package bch_pkg SHALL hold M/K defaults, PRIM_POLY, the FSM state enum, and the alpha-power/syndrome functions.
REQ-022 SHALL instantiate sub-module gf_mul (combinational GF(2^M) multiplier, parameter M and PRIM_POLY) for the S1^2, S1^3 and Chien constant multiplies.

Verification
REQ-023 All-zero in_cw -> out_valid at C+3, out_data=0, out_syn=0, out_err/out_sgl/out_dbl/out_unc=0.
REQ-024 Zero codeword with bit 40 flipped -> out_valid at C+3+44, out_sgl=1, out_data=0, out_err=1.
REQ-025 Zero codeword with bits 12 and 37 flipped -> out_dbl=1, out_data=0; the mask equals bits {12,37}.
REQ-026 Zero codeword with bits 0,1,2 flipped -> out_err=1 and exactly one of out_sgl/out_dbl/out_unc set; when out_unc=1, out_data = in_cw[43:12].
REQ-027 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout; in_valid held 1 accepts the next word only after the handshake.
REQ-028 rst_n pulsed low at C+20 (Chien path) -> out_valid=0 immediately and no result after release; the next codeword decodes correctly.
